// File: rtl/systolic_drain.sv
// systolic_drain: one FIFO per array row, drained as a row-major valid/ready stream with sticky overflow.
// Optional macro SYSTOLIC_DRAIN_RELU_EN clamps negative words to zero on the FIFO-to-output path.
module systolic_drain #(
  parameter int D_W_ACC    = 32,
  parameter int N1         = 8,
  parameter int N2         = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush,
  input  logic [N1-1:0]                          valid_D,
  input  logic [N1*D_W_ACC-1:0]                  D,
  output logic                                   m_valid,
  input  logic                                   m_ready,
  output logic signed [D_W_ACC-1:0]              m_data,
  output logic [((N1 > 1) ? $clog2(N1) : 1)-1:0] m_row,
  output logic [((N2 > 1) ? $clog2(N2) : 1)-1:0] m_col,
  output logic                                   m_last,
  output logic                                   ovf,
  output logic                                   busy
);

  localparam int RW = (N1 > 1) ? $clog2(N1) : 1;
  localparam int CW = (N2 > 1) ? $clog2(N2) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [RW-1:0] ROW_MAX = RW'(N1 - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(N2 - 1);
  localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0]   PTR_TWO = (AW+1)'(2);
  localparam logic [AW:0]   DEPTH_V = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

  state_t                         state, state_nxt;
  logic [N1-1:0]                  empty, full, push, pop, drop;
  logic [N1-1:0][AW:0]            fill_v;
  logic [N1-1:0][D_W_ACC-1:0]     head0, head1;
  logic [RW-1:0]                  row_idx, nxt_row;
  logic [CW-1:0]                  col_idx, nxt_col;
  logic                           same_row, nxt_avail, load, hshk, vld_p1;
  logic signed [D_W_ACC-1:0]      word_p0, data_p1;

  function automatic logic signed [D_W_ACC-1:0] relu_clamp(input logic signed [D_W_ACC-1:0] x);
`ifdef SYSTOLIC_DRAIN_RELU_EN
    relu_clamp = x[D_W_ACC-1] ? '0 : x;
`else
    relu_clamp = x;
`endif
  endfunction

  // Stage p0: per-row capture FIFOs; the held output word stays in its FIFO until the handshake pops it
  for (genvar gi = 0; gi < N1; gi++) begin : g_row
    logic [AW:0]               wp, rp, rp_n;
    logic signed [D_W_ACC-1:0] mem [FIFO_DEPTH];

    assign rp_n       = rp + PTR_ONE;
    assign fill_v[gi] = wp - rp;
    assign empty[gi]  = (wp == rp);
    assign full[gi]   = (fill_v[gi] == DEPTH_V);
    assign pop[gi]    = hshk && (row_idx == RW'(gi));
    assign drop[gi]   = valid_D[gi] && full[gi] && !pop[gi] && !flush;
    assign push[gi]   = valid_D[gi] && !flush && !(full[gi] && !pop[gi]);
    assign head0[gi]  = mem[rp[AW-1:0]];
    assign head1[gi]  = mem[rp_n[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wp <= '0;
        rp <= '0;
      end else if (flush) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (push[gi]) wp <= wp + PTR_ONE;
        if (pop[gi])  rp <= rp_n;
      end
    end

    always_ff @(posedge clk) begin
      if (push[gi]) mem[wp[AW-1:0]] <= D[gi*D_W_ACC +: D_W_ACC];
    end
  end

  always_comb begin
    nxt_row = row_idx;
    nxt_col = col_idx + CW'(1);
    if (col_idx == COL_MAX) begin
      nxt_col = '0;
      nxt_row = (row_idx == ROW_MAX) ? '0 : row_idx + RW'(1);
    end
  end

  // Back-to-back reload within one row reads the entry behind the one being popped
  assign same_row  = (nxt_row == row_idx);
  assign nxt_avail = same_row ? (fill_v[row_idx] >= PTR_TWO) : !empty[nxt_row];
  assign word_p0   = (state == LOAD) ? head0[row_idx]
                   : (same_row ? head1[row_idx] : head0[nxt_row]);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    hshk      = 1'b0;
    if (!flush) begin
      case (state)
        IDLE: if (!empty[row_idx]) state_nxt = LOAD;
        LOAD: begin
          load      = 1'b1;
          state_nxt = HOLD;
        end
        HOLD: if (m_ready) begin
          hshk = 1'b1;
          if (nxt_avail) load = 1'b1;
          else           state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Stage p1: output register and drain indices
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      row_idx <= '0;
      col_idx <= '0;
      data_p1 <= '0;
      ovf     <= 1'b0;
    end else if (flush) begin
      state   <= IDLE;
      row_idx <= '0;
      col_idx <= '0;
      ovf     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (hshk) begin
        row_idx <= nxt_row;
        col_idx <= nxt_col;
      end
      if (load)  data_p1 <= relu_clamp(word_p0);
      if (|drop) ovf     <= 1'b1;
    end
  end

  assign vld_p1  = (state == HOLD);
  assign m_valid = vld_p1;
  assign m_data  = data_p1;
  assign m_row   = row_idx;
  assign m_col   = col_idx;
  assign m_last  = vld_p1 && (row_idx == ROW_MAX) && (col_idx == COL_MAX);
  assign busy    = (|(~empty)) || vld_p1;

endmodule

// File: tb/tb_systolic_drain.sv
// Directed table-driven bench for systolic_drain: tile order, back-pressure, overflow,
// full push+pop, flush, ReLU option and mid-tile reset.
`timescale 1ns/1ps
module tb_systolic_drain;
  localparam int DW = 32;
  localparam int N1 = 8;
  localparam int N2 = 4;
  localparam int FD = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 flush = 1'b0;
  logic                 m_ready = 1'b0;
  logic [N1-1:0]        valid_D = '0;
  logic [N1*DW-1:0]     D = '0;
  logic                 m_valid, m_last, ovf, busy;
  logic signed [DW-1:0] m_data;
  logic [2:0]           m_row;
  logic [1:0]           m_col;

  systolic_drain #(.D_W_ACC(DW), .N1(N1), .N2(N2), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .flush(flush), .valid_D(valid_D), .D(D),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_row(m_row),
    .m_col(m_col), .m_last(m_last), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int row; int col; int data; logic last; } exp_t;
  typedef struct { int din; int exp_out; } vec_t;

  exp_t tile_tab [N1*N2];
  vec_t relu_tab [4];
  exp_t exp_q [$];
  exp_t held;
  logic held_vld = 1'b0;
  logic tog = 1'b0;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Output monitor: every accepted word against the expected queue, plus stall stability
  always @(negedge clk) begin
    if (rst && held_vld && m_valid) begin
      chk("stall_data", int'(m_data), held.data);
      chk("stall_row", int'(m_row), held.row);
      chk("stall_col", int'(m_col), held.col);
      chk("stall_last", int'(m_last), int'(held.last));
    end
    if (rst && m_valid && !m_ready) begin
      held     = '{int'(m_row), int'(m_col), int'(m_data), m_last};
      held_vld = 1'b1;
    end else begin
      held_vld = 1'b0;
    end
    if (rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got data %0d row %0d col %0d, none required", m_data, m_row, m_col);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_data", int'(m_data), e.data);
        chk("out_row", int'(m_row), e.row);
        chk("out_col", int'(m_col), e.col);
        chk("out_last", int'(m_last), int'(e.last));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (tog) m_ready = ~m_ready;
  endtask

  task automatic put(input int row, input int val);
    valid_D[row] = 1'b1;
    D[row*DW +: DW] = val;
  endtask

  task automatic push_tile(input logic [N1-1:0] mask);
    for (int j = 0; j < N2; j++) begin
      valid_D = '0;
      for (int i = 0; i < N1; i++) if (mask[i]) put(i, 100*i + j);
      tick();
    end
    valid_D = '0;
  endtask

  task automatic enq_range(input int first, input int last_i);
    for (int k = first; k <= last_i; k++) exp_q.push_back(tile_tab[k]);
  endtask

  task automatic wait_q(input string nm, input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    chk(nm, exp_q.size(), 0);
    exp_q.delete();
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N1; i++)
      for (int j = 0; j < N2; j++)
        tile_tab[i*N2 + j] = '{i, j, 100*i + j, (i == N1-1) && (j == N2-1)};
`ifdef SYSTOLIC_DRAIN_RELU_EN
    relu_tab[0] = '{-5, 0};
    relu_tab[1] = '{7, 7};
    relu_tab[2] = '{int'(32'h8000_0000), 0};
    relu_tab[3] = '{0, 0};
`else
    relu_tab[0] = '{-5, -5};
    relu_tab[1] = '{7, 7};
    relu_tab[2] = '{int'(32'h8000_0000), int'(32'h8000_0000)};
    relu_tab[3] = '{0, 0};
`endif

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_data", int'(m_data), 0);
    chk("rst_m_row", int'(m_row), 0);
    chk("rst_m_col", int'(m_col), 0);
    chk("rst_m_last", int'(m_last), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b1;
    tick();

    // Single tile, m_ready held high, with first-word latency
    m_ready = 1'b1;
    enq_range(0, N1*N2-1);
    for (int j = 0; j < N2; j++) begin
      valid_D = '0;
      for (int i = 0; i < N1; i++) put(i, 100*i + j);
      tick();
      chk("latency_valid", int'(m_valid), (j >= 2) ? 1 : 0);
    end
    valid_D = '0;
    wait_q("tile_drained", 200);
    chk("tile_ovf", int'(ovf), 0);
    chk("tile_busy", int'(busy), 0);

    // Same tile with m_ready toggling every cycle
    tog = 1'b1;
    enq_range(0, N1*N2-1);
    push_tile('1);
    wait_q("bp_drained", 300);
    tog = 1'b0;
    m_ready = 1'b0;
    tick();
    chk("bp_ovf", int'(ovf), 0);
    chk("bp_busy", int'(busy), 0);

    // Overflow: nine pushes into row 0 with the output stalled
    for (int k = 0; k < FD + 1; k++) begin
      valid_D = '0;
      put(0, 1000 + k);
      tick();
      if (k == FD - 1) chk("ovf_at_full", int'(ovf), 0);
      if (k == FD)     chk("ovf_on_9th", int'(ovf), 1);
    end
    valid_D = '0;
    for (int j = 0; j < N2; j++) exp_q.push_back('{0, j, 1000 + j, 1'b0});
    enq_range(N2, N1*N2-1);
    for (int j = 0; j < N2; j++) exp_q.push_back('{0, j, 1004 + j, 1'b0});
    m_ready = 1'b1;
    push_tile(8'hFE);
    wait_q("ovf_drained", 300);
    chk("ovf_ninth_lost_busy", int'(busy), 0);
    chk("ovf_sticky", int'(ovf), 1);

    // Flush mid-tile with five buffered words and ovf set
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      valid_D = '0;
      put(1, 2000 + k);
      tick();
    end
    valid_D = '0;
    tick();
    tick();
    chk("pre_flush_valid", int'(m_valid), 1);
    chk("pre_flush_row", int'(m_row), 1);
    flush = 1'b1;
    put(1, 2005);
    tick();
    flush = 1'b0;
    valid_D = '0;
    chk("flush_busy", int'(busy), 0);
    chk("flush_ovf", int'(ovf), 0);
    chk("flush_valid", int'(m_valid), 0);
    chk("flush_row", int'(m_row), 0);
    chk("flush_col", int'(m_col), 0);
    tick();
    chk("flush_discard_busy", int'(busy), 0);
    m_ready = 1'b1;
    enq_range(0, N1*N2-1);
    push_tile('1);
    wait_q("post_flush_tile", 200);
    chk("post_flush_busy", int'(busy), 0);

    // Full row 3 FIFO with push and handshake pop in the same cycle
    enq_range(0, 3*N2-1);
    push_tile(8'h07);
    wait_q("rows012_drained", 200);
    m_ready = 1'b0;
    for (int k = 0; k < FD; k++) begin
      valid_D = '0;
      put(3, 3000 + k);
      tick();
    end
    valid_D = '0;
    tick();
    tick();
    chk("full_hold_valid", int'(m_valid), 1);
    chk("full_hold_row", int'(m_row), 3);
    chk("full_hold_col", int'(m_col), 0);
    chk("full_hold_data", int'(m_data), 3000);
    chk("full_hold_ovf", int'(ovf), 0);
    exp_q.push_back('{3, 0, 3000, 1'b0});
    put(3, 3008);
    m_ready = 1'b1;
    tick();
    valid_D = '0;
    m_ready = 1'b0;
    chk("pushpop_ovf", int'(ovf), 0);
    chk("pushpop_consumed", exp_q.size(), 0);
    chk("pushpop_next_col", int'(m_col), 1);
    chk("pushpop_next_data", int'(m_data), 3001);
    put(3, 3009);
    tick();
    valid_D = '0;
    chk("still_full_ovf", int'(ovf), 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // Output-path sign handling
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back('{0, k, relu_tab[k].exp_out, 1'b0});
    for (int k = 0; k < 4; k++) begin
      valid_D = '0;
      put(0, relu_tab[k].din);
      tick();
    end
    valid_D = '0;
    wait_q("relu_drained", 100);
    chk("relu_busy", int'(busy), 0);

    // Reset asserted mid-tile, drain restarts at row 0 col 0
    m_ready = 1'b0;
    put(1, 55);
    tick();
    valid_D = '0;
    put(1, 56);
    tick();
    valid_D = '0;
    tick();
    tick();
    chk("mid_valid", int'(m_valid), 1);
    chk("mid_row", int'(m_row), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", int'(m_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_row", int'(m_row), 0);
    chk("mid_rst_data", int'(m_data), 0);
    tick();
    rst = 1'b1;
    tick();
    m_ready = 1'b1;
    exp_q.push_back('{0, 0, 42, 1'b0});
    put(0, 42);
    tick();
    valid_D = '0;
    wait_q("after_reset_word", 50);
    chk("after_reset_ovf", int'(ovf), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
